uut_result_logger: RTL and testbench

//  Sits between the UUT and the sdspihost byte-write port, beside the autotest FSM.
//  On a start pulse it counts clk cycles until the UUT raises end_uut, or until a timeout.
//  It then captures output_from_UUT and the cycle count into a fixed record.
//  It streams that record byte by byte to sdspihost via the w_byte/busy handshake, so latency and result reach the SD card.

---
 rtl/autotest_pkg.sv | 19 +
 rtl/spi_byte_writer.sv | 57 +++++
 rtl/uut_result_logger.sv | 133 +++++++++++++
 tb/tb_uut_result_logger.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/autotest_pkg.sv
// rtl/autotest_pkg.sv - shared types and constants for the UUT result logger
package autotest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } logger_state_t;

  localparam logic [7:0] HDR_BYTE           = 8'hA5;
  localparam int         STATUS_TIMEOUT_BIT = 0;

  // Header + status + counter bytes + result bytes.
  function automatic int record_bytes(input int cnt_width, input int output_size);
    return 2 + cnt_width / 8 + output_size / 8;
  endfunction

endpackage

// File: rtl/spi_byte_writer.sv
// rtl/spi_byte_writer.sv - hands one byte to sdspihost over the w_byte/busy handshake
module spi_byte_writer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       more,
  input  logic [7:0] data,
  output logic       ack,
  input  logic       spi_busy,
  output logic       spi_w_byte,
  output logic [7:0] spi_data_in
);

  localparam logic [2:0] WR_IDLE      = 3'd0;
  localparam logic [2:0] WR_WAIT_IDLE = 3'd1;
  localparam logic [2:0] WR_STROBE    = 3'd2;
  localparam logic [2:0] WR_WAIT_ACK  = 3'd3;
  localparam logic [2:0] WR_WAIT_DONE = 3'd4;

  logic [2:0] wr_state;

  // With more set, the next byte starts straight from WAIT_DONE without an idle hop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state    <= WR_IDLE;
      spi_data_in <= 8'h00;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (req) wr_state <= WR_WAIT_IDLE;
        end
        WR_WAIT_IDLE: begin
          if (!spi_busy) begin
            spi_data_in <= data;
            wr_state    <= WR_STROBE;
          end
        end
        WR_STROBE: begin
          wr_state <= WR_WAIT_ACK;
        end
        WR_WAIT_ACK: begin
          if (spi_busy) wr_state <= WR_WAIT_DONE;
        end
        WR_WAIT_DONE: begin
          if (!spi_busy) wr_state <= more ? WR_WAIT_IDLE : WR_IDLE;
        end
        default: begin
          wr_state <= WR_IDLE;
        end
      endcase
    end
  end

  assign spi_w_byte = (wr_state == WR_STROBE);
  assign ack        = (wr_state == WR_WAIT_DONE) && !spi_busy;

endmodule

// File: rtl/uut_result_logger.sv
// rtl/uut_result_logger.sv - times a UUT run and streams {HDR, STATUS, count, result} to sdspihost
module uut_result_logger
  import autotest_pkg::*;
#(
  parameter int OUTPUT_SIZE    = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 2 ** 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   end_uut,
  input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
  input  logic                   spi_busy,
  output logic                   spi_w_byte,
  output logic [7:0]             spi_data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out
);

  localparam int N_BYTES = record_bytes(CNT_WIDTH, OUTPUT_SIZE);
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int REC_W   = 8 * N_BYTES;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_BYTES - 1);

  if ((OUTPUT_SIZE % 8) != 0 || OUTPUT_SIZE < 8) begin : g_bad_output_size
    $error("OUTPUT_SIZE must be a non-zero multiple of 8");
  end
  if ((CNT_WIDTH % 8) != 0 || CNT_WIDTH < 8) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1 || (CNT_WIDTH < 31 && TIMEOUT_CYCLES >= (1 << CNT_WIDTH))) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
  end

  logger_state_t          state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [CNT_WIDTH-1:0]   cap_cnt;
  logic [OUTPUT_SIZE-1:0] cap_out;
  logic [IDX_W-1:0]       byte_idx;
  logic [7:0]             status_byte;
  logic [7:0]             cur_byte;
  logic [REC_W-1:0]       rec_bits;
  logic [REC_W-1:0]       rec_shifted;
  logic                   wr_req;
  logic                   wr_more;
  logic                   wr_ack;

  assign cnt_next = cnt + CNT_ONE;

  // Leaving RUN at TIMEOUT_VAL is what keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_cnt   <= '0;
      cap_out   <= '0;
      byte_idx  <= '0;
      timed_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt_next;
          if (end_uut || cnt_next == TIMEOUT_VAL) begin
            cap_cnt   <= cnt_next;
            cap_out   <= output_from_UUT;
            timed_out <= !end_uut;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          byte_idx <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (wr_ack) begin
            if (byte_idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status_byte                     = 8'h00;
    status_byte[STATUS_TIMEOUT_BIT] = timed_out;
  end

  // Record is MSB-first, so byte k is the top byte after shifting left by k bytes.
  assign rec_bits    = {HDR_BYTE, status_byte, cap_cnt, cap_out};
  assign rec_shifted = rec_bits << {byte_idx, 3'b000};
  assign cur_byte    = rec_shifted[REC_W-1 -: 8];

  assign wr_req  = (state == ST_LOAD);
  assign wr_more = (byte_idx != LAST_IDX);
  assign busy    = (state != ST_IDLE);

  spi_byte_writer u_writer (
    .clk         (clk),
    .rst         (rst),
    .req         (wr_req),
    .more        (wr_more),
    .data        (cur_byte),
    .ack         (wr_ack),
    .spi_busy    (spi_busy),
    .spi_w_byte  (spi_w_byte),
    .spi_data_in (spi_data_in)
  );

endmodule

// File: tb/tb_uut_result_logger.sv
// tb/tb_uut_result_logger.sv - randomized self-checking bench for uut_result_logger
module tb_uut_result_logger;

  localparam int OUT_W = 32;
  localparam int CNT_W = 32;
  localparam int TMO   = 16;
  localparam int NREC  = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             end_uut = 1'b0;
  logic [OUT_W-1:0] output_from_UUT = '0;
  logic             spi_busy = 1'b0;
  logic             spi_w_byte;
  logic [7:0]       spi_data_in;
  logic             busy;
  logic             done;
  logic             timed_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uut_result_logger #(
    .OUTPUT_SIZE    (OUT_W),
    .CNT_WIDTH      (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .end_uut         (end_uut),
    .output_from_UUT (output_from_UUT),
    .spi_busy        (spi_busy),
    .spi_w_byte      (spi_w_byte),
    .spi_data_in     (spi_data_in),
    .busy            (busy),
    .done            (done),
    .timed_out       (timed_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sdspihost stand-in: 3 busy cycles per byte, optional long hold, optional missing ack
  logic [7:0] got_q[$];
  int         strobes = 0;
  int         done_cnt = 0;
  int         done_wide = 0;
  int         busy_cnt = 0;
  int         hold_after = 0;
  int         hold_left = 0;
  int         hold_strobes = 0;
  int         hold_changes = 0;
  int         no_ack_on = 0;
  logic [7:0] hold_data = 8'h00;
  logic       done_prev = 1'b0;
  time        first_strobe_t = 0;

  initial forever begin
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (hold_left > 0) begin
      hold_left--;
      if (spi_w_byte) hold_strobes++;
      if (spi_data_in !== hold_data) hold_changes++;
    end
    if (spi_w_byte) begin
      strobes++;
      got_q.push_back(spi_data_in);
      if (strobes == 1) first_strobe_t = $time;
      if (strobes != no_ack_on) busy_cnt = 3;
      if (strobes == hold_after) begin
        hold_left = 50;
        hold_data = spi_data_in;
      end
    end
    if (done) begin
      done_cnt++;
      if (done_prev) done_wide++;
    end
    done_prev = done;
    spi_busy  = (busy_cnt > 0) || (hold_left > 0);
  end

  // d = cycle index at which end_uut is first sampled high; d > TMO means it never rises.
  task automatic do_run(input int d, input logic [31:0] ov, input bit extra_starts, input int abort_at);
    int         eff;
    bit         exp_to;
    bit         pulsed;
    int         k;
    time        t0;
    logic [7:0] exp_q[$];
    logic [31:0] exp_cnt;
    exp_to  = (d > TMO);
    eff     = exp_to ? TMO : d;
    exp_cnt = eff;
    exp_q   = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back({7'b0, exp_to});
    for (int b = 3; b >= 0; b--) exp_q.push_back(exp_cnt[8*b +: 8]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(ov[8*b +: 8]);

    got_q.delete();
    strobes        = 0;
    done_cnt       = 0;
    first_strobe_t = 0;
    t0             = 0;
    for (int j = 0; j <= eff + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        t0              = $time;
        output_from_UUT = ov;
      end
      start = (j == 0) || (extra_starts && j == 2);
      if (!exp_to && j == ((d == 1) ? 0 : d)) end_uut = 1'b1;
      if (j == eff + 1) begin
        end_uut         = 1'b0;
        output_from_UUT = $urandom;
      end
    end

    if (abort_at > 0) begin
      for (k = 0; k < 2000 && strobes < abort_at; k++) begin
        @(negedge clk);
        start = 1'b0;
      end
      check("abort_reach", (strobes >= abort_at), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_w_byte", spi_w_byte, 0);
      check("rst_data", spi_data_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timed_out", timed_out, 0);
      repeat (3) @(negedge clk);
      check("rst_no_done", done_cnt, 0);
      rst = 1'b1;
      return;
    end

    pulsed = 1'b0;
    for (k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clk);
      start = extra_starts && strobes == 3 && !pulsed;
      if (start) pulsed = 1'b1;
    end
    start = 1'b0;
    check("done_seen", (done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check("latency", (first_strobe_t - t0) / 10, eff + 3);
    check("strobes", strobes, NREC);
    check("done_count", done_cnt, 1);
    check("timed_out", timed_out, exp_to);
    check("busy_after", busy, 0);
    check("data_hold", spi_data_in, exp_q[NREC-1]);
    for (int i = 0; i < NREC; i++)
      check($sformatf("byte%0d", i), (got_q.size() > i) ? {56'd0, got_q[i]} : 64'hBAD0, exp_q[i]);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_w_byte", spi_w_byte, 0);
    check("reset_data", spi_data_in, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_timed_out", timed_out, 0);
    @(negedge clk);
    rst = 1'b1;

    do_run(5, 32'hDEADBEEF, 1'b0, 0);
    do_run(100, $urandom, 1'b0, 0);
    do_run(1, $urandom, 1'b0, 0);
    do_run(TMO, $urandom, 1'b0, 0);

    hold_after   = 2;
    hold_strobes = 0;
    hold_changes = 0;
    do_run(7, $urandom, 1'b0, 0);
    hold_after = 0;
    check("hold_no_strobe", hold_strobes, 0);
    check("hold_data_stable", hold_changes, 0);

    do_run(9, $urandom, 1'b1, 0);

    no_ack_on = 4;
    do_run(6, $urandom, 1'b0, 4);
    no_ack_on = 0;
    do_run(5, 32'hDEADBEEF, 1'b0, 0);

    for (int r = 0; r < 6; r++)
      do_run($urandom_range(1, 20), $urandom, 1'($urandom_range(0, 1)), 0);

    check("done_single_cycle", done_wide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
